ram_arbiter_n: RTL and testbench
================================

RAM_ARBITER_N -- requirements
Module: ram_arbiter_n

Interface
REQ-001 SHALL have parameter NCH, default 2, number of requester channels (1..8).
REQ-002 SHALL have parameter AW, default 15, per-channel word address width; backing store has 2^AW words.
REQ-003 SHALL have parameter DW, default 8, data width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port a  input  NCH*AW  channel addresses, channel i at [i*AW +: AW].
REQ-007 SHALL have port cs_n  input  NCH  chip select per channel, active-low.
REQ-008 SHALL have port oe_n  input  NCH  read strobe per channel, active-low.
REQ-009 SHALL have port we_n  input  NCH  write strobe per channel, active-low.
REQ-010 SHALL have port din  input  NCH*DW  write data, channel i at [i*DW +: DW].
REQ-011 SHALL have port dout  output  NCH*DW  registered read data per channel.
REQ-012 SHALL have port done  output  NCH  one-cycle pulse per completed access.

Function
REQ-013 SHALL register rd_lvl[i]=cs_n[i]|oe_n[i] and wr_lvl[i]=cs_n[i]|we_n[i] each cycle; a request is the combinational 1->0 transition of current level versus registered level.
REQ-014 SHALL, on a request edge, capture address (and din for writes) and set the channel's pending flag with type at that rising edge.
REQ-015 SHALL give read precedence when read and write edges occur on one channel in the same cycle.
REQ-016 SHALL let a new edge on a channel with a pending request replace it (latest wins, type and address overwritten).
REQ-017 SHALL use one shared single-port array; at most one access per two cycles.
REQ-018 SHALL implement FSM IDLE->GRANT when any pending flag is set (grant index latched); GRANT->IDLE unconditionally after the access.
REQ-019 SHALL, in GRANT, write mem[addr] <= data or load dout[g] <= mem[addr], and pulse done[g] high for exactly the following cycle.
REQ-020 SHALL clear the granted pending flag at the access edge unless a new edge on that channel arrives in the same cycle, which then remains pending.
REQ-021 SHALL deliver uncontended latency of 2 edges: request captured at E0, grant at E1, dout/done valid after E2.
REQ-022 SHALL hold dout[i] unchanged except on channel i read completion; writes never alter dout.
REQ-023 SHALL wrap addresses modulo 2^AW; no out-of-range condition exists.

Reset
REQ-024 SHALL, while rst_n low, force state IDLE, all pending clear, done=0, dout=0, registered levels all-ones, round-robin pointer 0.
REQ-025 SHALL abandon any in-flight access on reset mid-GRANT, with no memory write and no done pulse; memory contents are not reset.

Configuration
REQ-026 SHALL, with RAM_ARB_ROUND_ROBIN_EN defined, grant the lowest pending index at or above pointer (cyclically); pointer becomes grant+1 mod NCH after each grant.
REQ-027 SHALL, without RAM_ARB_ROUND_ROBIN_EN, use fixed priority: lowest pending index wins; no pointer logic.

Structure
REQ-028 SHALL place FSM state type (IDLE, GRANT) and request-type encoding in shared package ram_arb_pkg.
REQ-029 SHALL instantiate sub-module ram_arb_chan once per channel (edge detect, capture registers, pending flag).

Verification
REQ-030 SHALL cover: ch0 write a=0x0123 d=0xA5, then ch0 read 0x0123 -> dout[ch0]=0xA5, done[0] pulse 2 edges after read edge.
REQ-031 SHALL cover: ch0 and ch1 reads in same cycle, fixed priority -> ch0 done at E2, ch1 done at E4.
REQ-032 SHALL cover: RAM_ARB_ROUND_ROBIN_EN, NCH=4, all channels re-request continuously -> grants 0,1,2,3,0 in order.
REQ-033 SHALL cover: ch1 write 0x10, then replacement write 0x20 to same address before grant -> single done, mem holds 0x20.
REQ-034 SHALL cover: rst_n low during GRANT of write 0x5A to 0x0004 -> memory word unchanged, done stays 0, dout=0.
REQ-035 SHALL cover: address 0x7FFF write 0x3C, read back -> 0x3C; read 0x0000 unaffected.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: types and helpers shared by the arbiter top, its per-channel
// front end and anyone who needs to decode arbiter state.
//   arb_state_e : arbiter FSM state (IDLE, GRANT)
//   req_type_e  : captured request type (read / write)
//   next_index  : cyclic successor of a channel index
package ram_arb_pkg;

  localparam int MAX_NCH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_type_e;

  // Successor of idx in a ring of n channels.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_n_if.sv
// ram_arbiter_n_if: bundle of the per-channel SRAM-style request signals.
//   a     : NCH*AW  channel addresses, channel i at [i*AW +: AW]
//   cs_n  : NCH     chip select per channel, active-low
//   oe_n  : NCH     read strobe per channel, active-low
//   we_n  : NCH     write strobe per channel, active-low
//   din   : NCH*DW  write data, channel i at [i*DW +: DW]
//   dout  : NCH*DW  registered read data per channel
//   done  : NCH     one-cycle completion pulse per channel
// master = requesters, slave = arbiter.
interface ram_arbiter_n_if #(
  parameter int NCH = 2,
  parameter int AW  = 15,
  parameter int DW  = 8
);
  logic [NCH*AW-1:0] a;
  logic [NCH-1:0]    cs_n;
  logic [NCH-1:0]    oe_n;
  logic [NCH-1:0]    we_n;
  logic [NCH*DW-1:0] din;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    done;

  modport master (output a, cs_n, oe_n, we_n, din, input dout, done);
  modport slave  (input a, cs_n, oe_n, we_n, din, output dout, done);
endinterface

// File: rtl/ram_arbiter_n_chan.sv
// ram_arb_chan: front end of one requester channel. Registers the read and
// write strobe levels, turns a falling level into a request, captures the
// address (and write data) and holds a pending flag until the arbiter
// serves it. A newer request overwrites an older unserved one.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_cs_n/i_oe_n/i_we_n : channel strobes (active-low)
//   i_addr, i_din        : channel address and write data
//   i_clr                : arbiter is performing this channel's access now
//   o_pend, o_type, o_addr, o_data : captured request (registered)
module ram_arb_chan
  import ram_arb_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cs_n,
  input  logic          i_oe_n,
  input  logic          i_we_n,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_din,
  input  logic          i_clr,
  output logic          o_pend,
  output req_type_e     o_type,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  logic          r_rd_lvl;
  logic          r_wr_lvl;
  logic          r_pend;
  req_type_e     r_type;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  logic w_rd_lvl;
  logic w_wr_lvl;
  logic w_rd_edge;
  logic w_wr_edge;

  // Strobe levels and 1->0 request edges against last cycle's levels.
  always_comb begin
    w_rd_lvl  = i_cs_n | i_oe_n;
    w_wr_lvl  = i_cs_n | i_we_n;
    w_rd_edge = r_rd_lvl & ~w_rd_lvl;
    w_wr_edge = r_wr_lvl & ~w_wr_lvl;
  end

  // Level history and request capture; a new edge wins over a clear so a
  // request arriving on the access edge stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_lvl <= 1'b1;
      r_wr_lvl <= 1'b1;
      r_pend   <= 1'b0;
      r_type   <= REQ_RD;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_rd_lvl <= w_rd_lvl;
      r_wr_lvl <= w_wr_lvl;
      if (w_rd_edge) begin
        // Read takes precedence over a simultaneous write edge.
        r_pend <= 1'b1;
        r_type <= REQ_RD;
        r_addr <= i_addr;
      end else if (w_wr_edge) begin
        r_pend <= 1'b1;
        r_type <= REQ_WR;
        r_addr <= i_addr;
        r_data <= i_din;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_pend = r_pend;
  assign o_type = r_type;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/ram_arbiter_n.sv
// ram_arbiter_n: shares one single-port RAM of 2^AW x DW words among NCH
// SRAM-style requesters. Each channel raises a request with a falling
// strobe; the arbiter grants one pending channel, performs the access on
// the following edge and pulses that channel's done for one cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (RAM contents are not reset)
//   bus   : ram_arbiter_n_if.slave (a, cs_n, oe_n, we_n, din, dout, done)
// Optional feature: define RAM_ARB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise the lowest pending channel index wins.
module ram_arbiter_n
  import ram_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 15,
  parameter int DW  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_arbiter_n_if.slave bus
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] w_pend;
  req_type_e      w_type [NCH];
  logic [AW-1:0]  w_addr [NCH];
  logic [DW-1:0]  w_data [NCH];
  logic [NCH-1:0] w_clr;

  logic [MAX_NCH-1:0] w_pend_ext;
  logic [GW-1:0]      w_sel;
  req_type_e          w_gnt_type;
  logic [AW-1:0]      w_gnt_addr;
  logic [DW-1:0]      w_gnt_data;

  arb_state_e     r_state;
  logic [GW-1:0]  r_gnt;
  logic [NCH-1:0] r_done;
  logic [DW-1:0]  r_dout [NCH];
  logic [DW-1:0]  r_mem  [2**AW];
`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic [GW-1:0]  r_ptr;
`endif

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_chan
      ram_arb_chan #(.AW(AW), .DW(DW)) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cs_n (bus.cs_n[g]),
        .i_oe_n (bus.oe_n[g]),
        .i_we_n (bus.we_n[g]),
        .i_addr (bus.a[g*AW +: AW]),
        .i_din  (bus.din[g*DW +: DW]),
        .i_clr  (w_clr[g]),
        .o_pend (w_pend[g]),
        .o_type (w_type[g]),
        .o_addr (w_addr[g]),
        .o_data (w_data[g])
      );
      assign bus.dout[g*DW +: DW] = r_dout[g];
    end
  endgenerate

  assign bus.done = r_done;

  // Pending flag of the granted channel drops on the access edge.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_clr[i] = (r_state == ST_GRANT) && (int'(r_gnt) == i);
    end
  end

  // Request selected by the arbitration policy.
`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    logic w_found;
    logic w_take;
    int   idx;
    w_pend_ext          = '0;
    w_pend_ext[NCH-1:0] = w_pend;
    w_sel               = '0;
    w_found             = 1'b0;
    w_take              = 1'b0;
    idx                 = 0;
    // Scan cyclically starting at the pointer; first pending hit wins.
    for (int k = 0; k < NCH; k++) begin
      idx     = int'(r_ptr) + k;
      idx     = (idx >= NCH) ? idx - NCH : idx;
      w_take  = w_pend_ext[3'(idx)] & ~w_found;
      w_sel   = w_take ? GW'(idx) : w_sel;
      w_found = w_found | w_take;
    end
  end
`else
  always_comb begin
    w_pend_ext          = '0;
    w_pend_ext[NCH-1:0] = w_pend;
    w_sel               = '0;
    // Descending scan so the lowest pending index is the last to land.
    for (int i = NCH - 1; i >= 0; i--) begin
      w_sel = w_pend_ext[3'(i)] ? GW'(i) : w_sel;
    end
  end
`endif

  // Captured request of the granted channel.
  always_comb begin
    w_gnt_type = w_type[r_gnt];
    w_gnt_addr = w_addr[r_gnt];
    w_gnt_data = w_data[r_gnt];
  end

  // Arbiter FSM: IDLE latches a grant, GRANT performs the read side of the
  // access and raises done for the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_dout[i] <= '0;
      end
`ifdef RAM_ARB_ROUND_ROBIN_EN
      r_ptr   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= '0;
          if (|w_pend) begin
            r_gnt   <= w_sel;
            r_state <= ST_GRANT;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            r_ptr   <= GW'(next_index(int'(w_sel), NCH));
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          r_done        <= '0;
          r_done[r_gnt] <= 1'b1;
          if (w_gnt_type == REQ_RD) begin
            r_dout[r_gnt] <= r_mem[w_gnt_addr];
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write side of the shared RAM; a reset forces IDLE, so an interrupted
  // grant never writes.
  always_ff @(posedge clk) begin
    if (r_state == ST_GRANT && w_gnt_type == REQ_WR) begin
      r_mem[w_gnt_addr] <= w_gnt_data;
    end
  end

endmodule

// File: tb/tb_ram_arbiter_n.sv
module tb_ram_arbiter_n;

  localparam int NCH = 4;
  localparam int AW  = 15;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_arbiter_n_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

  ram_arbiter_n #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: RAM contents, per-channel read data, arbitration pointer.
  logic [DW-1:0] m_mem [int];
  logic [DW-1:0] m_dout [NCH];
  int            m_ptr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    bus.cs_n = '1;
    bus.oe_n = '1;
    bus.we_n = '1;
  endtask

  task automatic req(input int ch, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.cs_n[ch] = 1'b0;
    if (wr) bus.we_n[ch] = 1'b0;
    else    bus.oe_n[ch] = 1'b0;
    bus.a[ch*AW +: AW]   = addr;
    bus.din[ch*DW +: DW] = data;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_dout[i] = '0;
    m_ptr = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    release_all();
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  // Single uncontended access; reports cycle of first done after request edge.
  task automatic access(input int ch, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        output int done_at, output int n_done, output logic [DW-1:0] dv);
    done_at = -1;
    n_done  = 0;
    dv      = '0;
    req(ch, wr, addr, data);
    tick();
    release_all();
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.done[ch]) begin
        n_done++;
        if (done_at < 0) begin
          done_at = c;
          dv = bus.dout[ch*DW +: DW];
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL reset_done got=%b exp=%b", bus.done, 4'b0000); end
    checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=%h", bus.dout, 32'h0); end
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) tick();
    checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL idle_done got=%b exp=%b", bus.done, 4'b0000); end
  endtask

  task automatic test_write_read();
    int d_at, n_d;
    logic [DW-1:0] dv;
    access(0, 1'b1, 15'h0123, 8'hA5, d_at, n_d, dv);
    m_mem[32'h0123] = 8'hA5;
    checks++; if (d_at !== 2) begin errors++; $display("FAIL wr_latency got=%0d exp=%0d", d_at, 2); end
    checks++; if (n_d !== 1) begin errors++; $display("FAIL wr_done_count got=%0d exp=%0d", n_d, 1); end
    checks++; if (dv !== 8'h00) begin errors++; $display("FAIL wr_keeps_dout got=%h exp=%h", dv, 8'h00); end
    access(0, 1'b0, 15'h0123, 8'h00, d_at, n_d, dv);
    checks++; if (d_at !== 2) begin errors++; $display("FAIL rd_latency got=%0d exp=%0d", d_at, 2); end
    checks++; if (dv !== 8'hA5) begin errors++; $display("FAIL rd_data got=%h exp=%h", dv, 8'hA5); end
    checks++; if (bus.dout[DW +: DW] !== 8'h00) begin errors++; $display("FAIL other_dout got=%h exp=%h", bus.dout[DW +: DW], 8'h00); end
  endtask

  task automatic test_same_cycle();
    logic [NCH-1:0] exp;
    apply_reset();
    req(0, 1'b0, 15'h0123, 8'h00);
    req(1, 1'b0, 15'h0123, 8'h00);
    tick();
    release_all();
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp = (c == 2) ? 4'b0001 : (c == 4) ? 4'b0010 : 4'b0000;
      checks++; if (bus.done !== exp) begin errors++; $display("FAIL same_cycle_done c=%0d got=%b exp=%b", c, bus.done, exp); end
    end
    checks++; if (bus.dout[DW +: DW] !== 8'hA5) begin errors++; $display("FAIL same_cycle_dout1 got=%h exp=%h", bus.dout[DW +: DW], 8'hA5); end
  endtask

  task automatic test_replace();
    logic [NCH-1:0] exp;
    int d_at, n_d;
    logic [DW-1:0] dv;
    apply_reset();
    req(0, 1'b0, 15'h0123, 8'h00);
    req(1, 1'b1, 15'h0050, 8'h10);
    tick();
    release_all();
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) req(1, 1'b1, 15'h0050, 8'h20);
      if (c == 3) release_all();
      tick();
      exp = (c == 2) ? 4'b0001 : (c == 4) ? 4'b0010 : 4'b0000;
      checks++; if (bus.done !== exp) begin errors++; $display("FAIL replace_done c=%0d got=%b exp=%b", c, bus.done, exp); end
    end
    m_mem[32'h0050] = 8'h20;
    access(1, 1'b0, 15'h0050, 8'h00, d_at, n_d, dv);
    checks++; if (dv !== 8'h20) begin errors++; $display("FAIL replace_mem got=%h exp=%h", dv, 8'h20); end
  endtask

  task automatic test_boundary();
    int d_at, n_d;
    logic [DW-1:0] dv;
    access(2, 1'b1, 15'h0000, 8'h77, d_at, n_d, dv);
    access(3, 1'b1, 15'h7FFF, 8'h3C, d_at, n_d, dv);
    m_mem[32'h0000] = 8'h77;
    m_mem[32'h7FFF] = 8'h3C;
    access(3, 1'b0, 15'h7FFF, 8'h00, d_at, n_d, dv);
    checks++; if (dv !== 8'h3C) begin errors++; $display("FAIL top_addr got=%h exp=%h", dv, 8'h3C); end
    access(2, 1'b0, 15'h0000, 8'h00, d_at, n_d, dv);
    checks++; if (dv !== 8'h77) begin errors++; $display("FAIL zero_addr got=%h exp=%h", dv, 8'h77); end
    checks++; if (d_at !== 2) begin errors++; $display("FAIL zero_latency got=%0d exp=%0d", d_at, 2); end
  endtask

  task automatic test_reset_mid_grant();
    int d_at, n_d;
    logic [DW-1:0] dv;
    access(1, 1'b1, 15'h0004, 8'h11, d_at, n_d, dv);
    m_mem[32'h0004] = 8'h11;
    req(0, 1'b1, 15'h0004, 8'h5A);
    tick();
    release_all();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL midrst_dout got=%h exp=%h", bus.dout, 32'h0); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL midrst_done c=%0d got=%b exp=%b", c, bus.done, 4'b0000); end
    end
    rst_n = 1'b1;
    model_reset();
    tick();
    access(2, 1'b0, 15'h0004, 8'h00, d_at, n_d, dv);
    checks++; if (dv !== 8'h11) begin errors++; $display("FAIL midrst_mem got=%h exp=%h", dv, 8'h11); end
    checks++; if (n_d !== 1) begin errors++; $display("FAIL midrst_count got=%0d exp=%0d", n_d, 1); end
  endtask

`ifdef RAM_ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [NCH-1:0] exp;
    apply_reset();
    bus.a = '0;
    for (int c = 0; c <= 10; c++) begin
      if (c % 2 == 0) begin
        bus.cs_n = '0;
        bus.oe_n = '0;
      end else begin
        release_all();
      end
      tick();
      exp = '0;
      if (c >= 2 && c % 2 == 0) exp[seq[c/2-1]] = 1'b1;
      checks++; if (bus.done !== exp) begin errors++; $display("FAIL rr_done c=%0d got=%b exp=%b", c, bus.done, exp); end
    end
    release_all();
    for (int c = 0; c < 16; c++) tick();
  endtask
`endif

  task automatic test_random();
    logic [AW-1:0]  pool [8] = '{15'h0000, 15'h7FFF, 15'h0123, 15'h0004, 15'h1234, 15'h4000, 15'h2AAA, 15'h0FF0};
    logic [NCH-1:0] mask, wr, exp_done;
    logic [AW-1:0]  ad [NCH];
    logic [DW-1:0]  dt [NCH];
    logic [NCH*DW-1:0] exp_dout;
    int order [$];
    int n, g;
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      mask = (it < 2) ? 4'b1111 : 4'($urandom_range(1, 15));
      wr   = (it < 2) ? 4'b1111 : 4'($urandom_range(0, 15));
      for (int i = 0; i < NCH; i++) begin
        ad[i] = (it < 2) ? pool[it*4 + i] : pool[$urandom_range(0, 7)];
        dt[i] = 8'($urandom_range(0, 255));
      end
      // Grant order from the arbitration rule.
      order.delete();
      for (int k = 0; k < NCH; k++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        g = (m_ptr + k) % NCH;
`else
        g = k;
`endif
        if (mask[g]) order.push_back(g);
      end
      n = order.size();
`ifdef RAM_ARB_ROUND_ROBIN_EN
      m_ptr = (order[n-1] + 1) % NCH;
`endif
      for (int i = 0; i < NCH; i++) if (mask[i]) req(i, wr[i], ad[i], dt[i]);
      tick();
      release_all();
      for (int c = 1; c <= 2*n + 2; c++) begin
        tick();
        exp_done = '0;
        if (c % 2 == 0 && c/2 - 1 < n) begin
          g = order[c/2 - 1];
          exp_done[g] = 1'b1;
          if (wr[g]) m_mem[int'(ad[g])] = dt[g];
          else       m_dout[g] = m_mem[int'(ad[g])];
        end
        for (int i = 0; i < NCH; i++) exp_dout[i*DW +: DW] = m_dout[i];
        checks++; if (bus.done !== exp_done) begin errors++; $display("FAIL rnd_done it=%0d c=%0d got=%b exp=%b", it, c, bus.done, exp_done); end
        checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL rnd_dout it=%0d c=%0d got=%h exp=%h", it, c, bus.dout, exp_dout); end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.a   = '0;
    bus.din = '0;
    release_all();
    model_reset();
    test_reset();
    test_write_read();
    test_same_cycle();
    test_replace();
    test_boundary();
    test_reset_mid_grant();
`ifdef RAM_ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
